// File: rtl/apb_rsp_fifo.sv
// Read-response capture FIFO that snoops APB completions on the SRAM clock and queues read results.
// Define APB_RSP_WRITE_ACK_EN to also queue write acknowledgements.
module apb_rsp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       sram_gclk,
    input  logic                       rstn,
    input  logic                       psel_i,
    input  logic                       penable_i,
    input  logic                       pwrite_i,
    input  logic                       pready_i,
    input  logic                       pslverr_i,
    input  logic [ADDR_WIDTH-1:0]      paddr_i,
    input  logic [DATA_WIDTH-1:0]      prdata_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DATA_WIDTH-1:0]      rsp_data_o,
    output logic [ADDR_WIDTH-1:0]      rsp_addr_o,
    output logic                       rsp_err_o,
    output logic                       rsp_is_write_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       overflow_o,
    input  logic                       clr_ovf_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic                  err_mem  [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic cpl;
    logic push_req;
    logic push;
    logic pop;
    logic drop;
    logic full;

    assign cpl  = psel_i & penable_i & pready_i;
    assign full = (count == FULL_COUNT);
    assign pop  = (count != '0) & rsp_ready_i;

`ifdef APB_RSP_WRITE_ACK_EN
    assign push_req = cpl;
`else
    assign push_req = cpl & ~pwrite_i;
`endif

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;

    always_ff @(posedge sram_gclk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf_i) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge sram_gclk) begin
        if (rstn && push) begin
            data_mem[wr_ptr] <= pwrite_i ? '0 : prdata_i;
            addr_mem[wr_ptr] <= paddr_i;
            err_mem[wr_ptr]  <= pslverr_i;
        end
    end

`ifdef APB_RSP_WRITE_ACK_EN
    logic wr_mem [DEPTH];

    always_ff @(posedge sram_gclk) begin
        if (rstn && push) begin
            wr_mem[wr_ptr] <= pwrite_i;
        end
    end

    assign rsp_is_write_o = wr_mem[rd_ptr];
`else
    assign rsp_is_write_o = 1'b0;
`endif

    assign rsp_valid_o = (count != '0);
    assign rsp_data_o  = data_mem[rd_ptr];
    assign rsp_addr_o  = addr_mem[rd_ptr];
    assign rsp_err_o   = err_mem[rd_ptr];
    assign count_o     = count;
    assign full_o      = full;
    assign overflow_o  = overflow;

endmodule

// File: doc/apb_rsp_fifo.md
# apb_rsp_fifo

Read-response capture buffer downstream of the APB SRAM slave. It snoops the APB completion handshake and queues each completed read as a response entry: data, address and error flag. It presents the queue to a consumer over a valid/ready interface, so read data is not lost after the APB transfer ends. It runs in the SRAM-side clock domain and is built from `apb_sram_pkg` widths.

## Interface
- `DATA_WIDTH`, default 32: response data width; matches `apb_sram_pkg::DATA_WIDTH`.
- `ADDR_WIDTH`, default 8: captured address width; matches `apb_sram_pkg::ADDR_WIDTH`.
- `DEPTH`, default 4: number of FIFO entries; power of two, ≥2.
- `sram_gclk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `psel_i`  in  1  APB PSEL (snooped).
- `penable_i`  in  1  APB PENABLE (snooped).
- `pwrite_i`  in  1  APB PWRITE (snooped).
- `pready_i`  in  1  APB PREADY from the slave.
- `pslverr_i`  in  1  APB PSLVERR from the slave.
- `paddr_i`  in  ADDR_WIDTH  APB PADDR.
- `prdata_i`  in  DATA_WIDTH  APB PRDATA.
- `rsp_valid_o`  out  1  head entry valid.
- `rsp_ready_i`  in  1  consumer accepts the head entry.
- `rsp_data_o`  out  DATA_WIDTH  head data.
- `rsp_addr_o`  out  ADDR_WIDTH  head address.
- `rsp_err_o`  out  1  head entry completed with PSLVERR.
- `rsp_is_write_o`  out  1  head entry is a write acknowledgement (see Configuration).
- `count_o`  out  $clog2(DEPTH+1)  current occupancy.
- `full_o`  out  1  count_o == DEPTH.
- `overflow_o`  out  1  sticky: a completion was dropped.
- `clr_ovf_i`  in  1  clears overflow_o.

## Operation
- Completion event: `cpl = psel_i & penable_i & pready_i`.
- Push condition: `cpl & !pwrite_i`; with the macro, also `cpl & pwrite_i`.
- A push writes {prdata_i, paddr_i, pslverr_i, pwrite_i} at the write pointer. For write entries, the data field stores 0.
- Pop condition: `rsp_valid_o & rsp_ready_i`.
- Storage is a circular buffer: read and write pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 → 0, plus an occupancy counter.
- The FIFO is first-word fall-through. `rsp_*` outputs are driven from the entry at the read pointer. `rsp_valid_o` = count_o != 0.
- Full:
  - A push while full without a simultaneous pop is dropped. Storage and pointers are unchanged, and overflow_o sets at that edge.
  - A push while full with a simultaneous pop is accepted. Count stays at DEPTH.
- Empty: a pop cannot occur, since valid is low. A push into an empty FIFO appears at the head on the next cycle; there is no same-cycle bypass.
- Simultaneous push and pop on a non-full, non-empty FIFO: both pointers advance and count is unchanged.
- overflow_o:
  - Set by a drop.
  - Cleared by clr_ovf_i.
  - If a drop and clr_ovf_i occur in the same cycle, set wins.
- The block never back-pressures APB. It is monitor-only and drives no APB signal.
- Reset (rstn low at an edge), including mid-operation:
  - Pointers and count go to 0 and overflow_o goes to 0, so rsp_valid_o = 0 and full_o = 0.
  - Pending entries are discarded.
  - Entry storage need not be reset; head outputs are don't-care while rsp_valid_o = 0.
  - A completion during reset is not captured.

## Timing
- Push latency: a completion sampled at edge N gives rsp_valid_o high from edge N onward, i.e. visible in cycle N+1.
- Pop: an entry is removed at the edge where valid & ready are both high. The next entry is presented in the following cycle.
- count_o, full_o and overflow_o are registered and update at the same edge as the push/pop that changes them.
- One completion at most per cycle. Back-to-back APB completions in consecutive cycles are all captured while space exists.

## Configuration
- Macro: `APB_RSP_WRITE_ACK_EN`.
- Defined:
  - Write completions are also pushed, with rsp_is_write_o = 1 and rsp_data_o = 0.
  - Write errors are reported via rsp_err_o.
- Undefined:
  - Only reads are pushed.
  - rsp_is_write_o is tied 0 and its storage bit is removed.

## Test plan
- Reset then idle: all outputs 0, count_o = 0; a PSEL/PENABLE cycle without PREADY pushes nothing.
- Single read of addr 0x05 returning 0xDEADBEEF, rsp_ready low → next cycle rsp_valid = 1, data 0xDEADBEEF, addr 0x05, err 0, count 1; assert ready → valid 0 after one edge.
- Five back-to-back reads with DEPTH = 4 and ready low → full_o = 1 after the 4th, 5th is dropped, overflow_o = 1; pop all and get the first four in order; clr_ovf_i → overflow_o = 0.
- Full FIFO with a completion and a pop in the same cycle → count stays 4, new entry appears last, overflow_o stays 0.
- Read to invalid address with pslverr_i = 1 → entry has rsp_err_o = 1. A write completion pushes only when `APB_RSP_WRITE_ACK_EN` is set, with rsp_is_write_o = 1 and data 0.
- rstn low with 3 entries queued, mid-completion → next cycle count 0, valid 0, overflow 0; the completion during reset is not queued; wrap-around verified by 10 push/pop pairs with in-order data.
